// File: rtl/qam16_demapper.sv
// qam16_demapper: two-stage 16-QAM hard-decision demapper.
// S1 registers the incoming Q1.11 I/Q sample; S2 registers the Gray-decoded
// symbol, the per-axis decision error and the erasure flag. Saturating symbol
// and erasure counters track accepted output decisions.
module qam16_demapper #(
  parameter int DATA_WIDTH = 12,
  parameter int SLICE_THR  = 1296,
  parameter int ERASE_THR  = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_sym,
  output logic signed [DATA_WIDTH-1:0] out_err_i,
  output logic signed [DATA_WIDTH-1:0] out_err_q,
  output logic                         out_erase,
  input  logic                         clr_stats,
  output logic [CNT_WIDTH-1:0]         sym_count,
  output logic [CNT_WIDTH-1:0]         erase_count
);

  // One extra bit of headroom so x - level never overflows before truncation.
  localparam int EW = DATA_WIDTH + 1;
  typedef logic signed [EW-1:0] wide_t;

  localparam wide_t THR_P   = wide_t'(SLICE_THR);
  localparam wide_t THR_N   = -THR_P;
  localparam wide_t LVL_IN  = wide_t'(648);
  localparam wide_t LVL_OUT = wide_t'(1943);
  localparam wide_t ERASE_W = wide_t'(ERASE_THR);
  localparam wide_t ZERO_W  = wide_t'(0);

  // Per-axis decision: Gray bit pair of the nearest constellation level.
  function automatic logic [1:0] slice_bits(input wide_t x);
    logic [1:0] b;
    if (x < THR_N) begin
      b = 2'b00;
    end else if (x < ZERO_W) begin
      b = 2'b01;
    end else if (x < THR_P) begin
      b = 2'b11;
    end else begin
      b = 2'b10;
    end
    return b;
  endfunction

  // Ideal amplitude associated with a Gray bit pair.
  function automatic wide_t level_of(input logic [1:0] b);
    wide_t l;
    case (b)
      2'b00:   l = -LVL_OUT;
      2'b01:   l = -LVL_IN;
      2'b11:   l = LVL_IN;
      default: l = LVL_OUT;
    endcase
    return l;
  endfunction

  // Magnitude at the wide width (operands stay well inside range).
  function automatic wide_t abs_w(input wide_t v);
    wide_t a;
    if (v < ZERO_W) begin
      a = -v;
    end else begin
      a = v;
    end
    return a;
  endfunction

  logic                         s1_valid_r;
  logic signed [DATA_WIDTH-1:0] s1_i_r;
  logic signed [DATA_WIDTH-1:0] s1_q_r;

  logic       s2_can_load_s;
  logic       s1_can_load_s;
  logic       out_hs_s;
  wide_t      xi_s;
  wide_t      xq_s;
  wide_t      diff_i_s;
  wide_t      diff_q_s;
  logic [1:0] bits_i_s;
  logic [1:0] bits_q_s;
  logic       erase_s;

  assign s2_can_load_s = !out_valid || out_ready;
  assign s1_can_load_s = !s1_valid_r || s2_can_load_s;
  assign in_ready      = s1_can_load_s;
  assign out_hs_s      = out_valid && out_ready;

  // Slice the S1 sample, form the decision errors and the erasure flag.
  always_comb begin
    xi_s     = {s1_i_r[DATA_WIDTH-1], s1_i_r};
    xq_s     = {s1_q_r[DATA_WIDTH-1], s1_q_r};
    bits_i_s = slice_bits(xi_s);
    bits_q_s = slice_bits(xq_s);
    diff_i_s = xi_s - level_of(bits_i_s);
    diff_q_s = xq_s - level_of(bits_q_s);
    erase_s  = (abs_w(diff_i_s) > ERASE_W) || (abs_w(diff_q_s) > ERASE_W);
  end

  // Stage 1: capture the raw sample whenever the stage can advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_i_r     <= '0;
      s1_q_r     <= '0;
    end else if (s1_can_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_i_r <= in_i;
        s1_q_r <= in_q;
      end else begin
        s1_i_r <= s1_i_r;
        s1_q_r <= s1_q_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: register the decision; contents hold while the output stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sym   <= 4'b0000;
      out_err_i <= '0;
      out_err_q <= '0;
      out_erase <= 1'b0;
    end else if (s2_can_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_sym   <= {bits_i_s, bits_q_s};
        out_err_i <= diff_i_s[DATA_WIDTH-1:0];
        out_err_q <= diff_q_s[DATA_WIDTH-1:0];
        out_erase <= erase_s;
      end else begin
        out_sym   <= out_sym;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating statistics; a clear wins over a coincident handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_count   <= '0;
      erase_count <= '0;
    end else if (clr_stats) begin
      sym_count   <= '0;
      erase_count <= '0;
    end else if (out_hs_s) begin
      if (sym_count != {CNT_WIDTH{1'b1}}) begin
        sym_count <= sym_count + CNT_WIDTH'(1);
      end else begin
        sym_count <= sym_count;
      end
      if (out_erase && (erase_count != {CNT_WIDTH{1'b1}})) begin
        erase_count <= erase_count + CNT_WIDTH'(1);
      end else begin
        erase_count <= erase_count;
      end
    end else begin
      sym_count <= sym_count;
    end
  end

endmodule

// File: tb/tb_qam16_demapper.sv
// Self-checking bench for qam16_demapper: directed cases from the test plan
// plus randomized traffic against a queue-based reference model. A second
// instance with 4-bit counters exercises counter saturation quickly.
module tb_qam16_demapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_i;
  logic [11:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_sym;
  logic [11:0] out_err_i;
  logic [11:0] out_err_q;
  logic        out_erase;
  logic        clr_stats;
  logic [15:0] sym_count;
  logic [15:0] erase_count;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [3:0]  sat_out_sym;
  logic [11:0] sat_err_i;
  logic [11:0] sat_err_q;
  logic        sat_erase;
  logic [3:0]  sat_sym_count;
  logic [3:0]  sat_erase_count;

  always #5 clk = ~clk;

  qam16_demapper dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_err_i(out_err_i), .out_err_q(out_err_q),
    .out_erase(out_erase), .clr_stats(clr_stats), .sym_count(sym_count),
    .erase_count(erase_count)
  );

  qam16_demapper #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_sym(sat_out_sym), .out_err_i(sat_err_i), .out_err_q(sat_err_q),
    .out_erase(sat_erase), .clr_stats(clr_stats), .sym_count(sat_sym_count),
    .erase_count(sat_erase_count)
  );

  typedef struct packed {
    logic [3:0]  sym;
    logic [11:0] ei;
    logic [11:0] eq;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_sym    = 0;
  int   m_era    = 0;
  bit   armed    = 1'b0;

  // Compare one observed value against its expectation and count it.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Nearest constellation amplitude and its Gray pair for one axis.
  function automatic void slice_ref(input int x, output int lvl, output logic [1:0] b);
    if (x < -1296)      begin lvl = -1943; b = 2'b00; end
    else if (x < 0)     begin lvl = -648;  b = 2'b01; end
    else if (x < 1296)  begin lvl = 648;   b = 2'b11; end
    else                begin lvl = 1943;  b = 2'b10; end
  endfunction

  function automatic int amp_of(input logic [1:0] b);
    case (b)
      2'b00:   return -1943;
      2'b01:   return -648;
      2'b11:   return 648;
      default: return 1943;
    endcase
  endfunction

  function automatic exp_t model(input logic [11:0] i, input logic [11:0] q);
    exp_t e;
    int xi, xq, li, lq, di, dq;
    logic [1:0] bi, bq;
    xi = $signed(i);
    xq = $signed(q);
    slice_ref(xi, li, bi);
    slice_ref(xq, lq, bq);
    di = xi - li;
    dq = xq - lq;
    e.sym = {bi, bq};
    e.ei  = 12'(di);
    e.eq  = 12'(dq);
    e.er  = (di > 512) || (di < -512) || (dq > 512) || (dq < -512);
    return e;
  endfunction

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic cycle(input logic v, input logic [11:0] i, input logic [11:0] q,
                       input logic ordy, input logic clr, input logic rst);
    exp_t head;
    bit   hs_in, hs_out;
    in_valid = v; in_i = i; in_q = q; out_ready = ordy; clr_stats = clr; rst_n = rst;
    #1;
    if (armed) begin
      check("sym_count", {16'b0, sym_count}, sat(m_sym, 65535));
      check("erase_count", {16'b0, erase_count}, sat(m_era, 65535));
      check("sat_sym_count", {28'b0, sat_sym_count}, sat(m_sym, 15));
      check("sat_erase_count", {28'b0, sat_erase_count}, sat(m_era, 15));
      check("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < 2) || ordy});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          head = exp_q[0];
          check("out_sym", {28'b0, out_sym}, {28'b0, head.sym});
          check("out_err_i", {20'b0, out_err_i}, {20'b0, head.ei});
          check("out_err_q", {20'b0, out_err_q}, {20'b0, head.eq});
          check("out_erase", {31'b0, out_erase}, {31'b0, head.er});
        end
      end
    end
    if (rst) begin
      hs_in  = v && in_ready;
      hs_out = out_valid && ordy && (exp_q.size() != 0);
      head   = '0;
      if (hs_out) head = exp_q.pop_front();
      if (clr) begin
        m_sym = 0;
        m_era = 0;
      end else if (hs_out) begin
        m_sym++;
        if (head.er) m_era++;
      end
      if (hs_in) exp_q.push_back(model(i, q));
    end else begin
      exp_q.delete();
      m_sym = 0;
      m_era = 0;
    end
    @(posedge clk);
    #1;
    if (!rst) armed = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1);
  endtask

  // Send a lone sample and check the registered decision two cycles later.
  task automatic directed(input string tag, input logic [11:0] i, input logic [11:0] q,
                          input logic [3:0] s, input logic [11:0] ei, input logic [11:0] eq,
                          input logic er);
    idle(3);
    cycle(1'b1, i, q, 1'b1, 1'b0, 1'b1);
    check({tag, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
    cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_sym"}, {28'b0, out_sym}, {28'b0, s});
    check({tag, "_err_i"}, {20'b0, out_err_i}, {20'b0, ei});
    check({tag, "_err_q"}, {20'b0, out_err_q}, {20'b0, eq});
    check({tag, "_erase"}, {31'b0, out_erase}, {31'b0, er});
  endtask

  int edge_vals[14] = '{-2048, 2047, -1297, -1296, -1295, -1, 0, 1295, 1296,
                        -648, 648, -1943, 1943, 1136};

  function automatic logic [11:0] rnd_sample();
    if ($urandom_range(0, 2) == 0) return 12'(edge_vals[$urandom_range(0, 13)]);
    return 12'($urandom_range(0, 4095));
  endfunction

  initial begin
    logic [3:0] s4;
    rst_n = 1'b0; in_valid = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b1; clr_stats = 1'b0;

    // Reset state.
    cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_sym_count", {16'b0, sym_count}, 32'd0);

    // Ideal constellation, back to back.
    for (int s = 0; s < 16; s++) begin
      s4 = 4'(s);
      cycle(1'b1, 12'(amp_of(s4[3:2])), 12'(amp_of(s4[1:0])), 1'b1, 1'b0, 1'b1);
    end
    idle(3);
    check("ideal_sym_count", {16'b0, sym_count}, 32'd16);
    check("ideal_erase_count", {16'b0, erase_count}, 32'd0);

    // Threshold and extreme boundaries.
    directed("thr", 12'd1295, 12'd1296, 4'b1110, 12'(647), 12'(-647), 1'b1);
    directed("zero", 12'd0, 12'hFFF, 4'b1101, 12'(-648), 12'(647), 1'b1);
    directed("ext", 12'h800, 12'h7FF, 4'b0010, 12'(-105), 12'(104), 1'b0);
    directed("negthr", 12'(-1296), 12'(-1297), 4'b0100, 12'(-648), 12'(646), 1'b1);

    // Output stall with input kept valid.
    for (int k = 0; k < 5; k++) cycle(1'b1, rnd_sample(), rnd_sample(), 1'b0, 1'b0, 1'b1);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 4; k++) cycle(1'b1, rnd_sample(), rnd_sample(), 1'b1, 1'b0, 1'b1);
    idle(3);

    // Clear coinciding with an output handshake.
    directed("pre_clr", 12'd648, 12'd648, 4'b1111, 12'd0, 12'd0, 1'b0);
    cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
    check("clr_sym_count", {16'b0, sym_count}, 32'd0);
    check("clr_erase_count", {16'b0, erase_count}, 32'd0);

    // Reset with two samples in flight.
    cycle(1'b1, rnd_sample(), rnd_sample(), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, rnd_sample(), rnd_sample(), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_sym_count", {16'b0, sym_count}, 32'd0);
    directed("post_rst", 12'(-648), 12'(1943), 4'b0110, 12'd0, 12'd0, 1'b0);

    // Randomized traffic with occasional clears and resets.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0,
            $urandom_range(0, 499) != 0);
    end

    // Saturation of the narrow counters on a long unbroken stream.
    idle(3);
    for (int k = 0; k < 40; k++) cycle(1'b1, 12'd1, 12'd700, 1'b1, 1'b0, 1'b1);
    idle(3);
    check("sat_sym_stop", {28'b0, sat_sym_count}, 32'd15);

    idle(6);
    check("drain_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qam16_demapper.md
Name: qam16_demapper

Overview:
- Receive-side counterpart of the 16-QAM mapper. It hard-slices symbol-rate Q1.11 I/Q samples to the nearest constellation level and Gray-decodes them back to 4-bit symbols.
- Also reports the per-axis decision error and keeps running symbol and erasure statistics.
- Sits after the matched filter and symbol-timing decimator; feeds the BER checker and the constellation display.

Parameters:
- DATA_WIDTH, 12, I/Q sample width, Q1.11 signed.
- SLICE_THR, 1296, decision threshold magnitude, midpoint of 648 and 1943.
- ERASE_THR, 512, |error| above which a decision counts as an erasure.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  demapper can accept a sample
- in_i  in  12  signed I sample, Q1.11
- in_q  in  12  signed Q sample, Q1.11
- out_valid  out  1  decision valid
- out_ready  in  1  downstream accepts the decision
- out_sym  out  4  decoded symbol {b3,b2,b1,b0}
- out_err_i  out  12  signed in_i minus the sliced I level
- out_err_q  out  12  signed in_q minus the sliced Q level
- out_erase  out  1  erasure flag, registered with the decision
- clr_stats  in  1  synchronous clear of both counters
- sym_count  out  16  accepted output symbols, saturating
- erase_count  out  16  accepted erasures, saturating

Behaviour:
- Reset (rst_n low at a clk edge): all pipeline valids, out_sym, out_err_i, out_err_q, out_erase, sym_count and erase_count go to 0. Reset mid-operation drops all in-flight samples. in_ready is 1 in the first cycle after reset.
- Pipeline structure: two stages.
  - S1 registers in_i and in_q.
  - S2 registers the decision, the errors and the erasure flag.
- Handshakes:
  - Every stage uses valid/ready. A stage loads when it is empty or when its content is being consumed in the same cycle.
  - in_ready = !s1_valid || s2_can_load, where s2_can_load = !out_valid || out_ready.
  - Full throughput is one sample per cycle with no bubbles. Latency from input handshake to out_valid is 2 cycles when out_ready stays high.
  - Output data is held stable while out_valid && !out_ready.
- Per-axis slicing, x signed, T = SLICE_THR:
  - x < -T → level -1943, bits 00
  - -T ≤ x < 0 → level -648, bits 01
  - 0 ≤ x < T → level +648, bits 11
  - x ≥ T → level +1943, bits 10
- Symbol mapping: the I axis gives {b3,b2} and the Q axis gives {b1,b0}. This is the exact inverse of the transmit mapper's Gray mapping.
- Error computation:
  - err = x - level. Compute at 13 bits; the result always fits 12-bit signed (range -648..+647), so truncate to 12 bits.
  - out_erase = (|err_i| > ERASE_THR) || (|err_q| > ERASE_THR), using a strict comparison.
- Statistics, updated on each output handshake (out_valid && out_ready):
  - sym_count increments; erase_count increments when out_erase is 1.
  - Both counters saturate at 0xFFFF and never wrap.
  - clr_stats has priority: if it coincides with a handshake, both counters become 0 and that symbol is not counted.
  - clr_stats does not affect the datapath.
- Boundary cases:
  - x = -2048 slices to -1943 with err = -105.
  - Exactly x = 0 slices to +648.
  - Exactly x = ±T: +T slices to +1943; -T slices to -648.

Test Plan:
- Stream the 16 ideal constellation points, one per cycle, with out_ready held at 1 → out_sym returns each 4-bit symbol in order with a 2-cycle latency; all errors are 0; erase_count stays 0; sym_count = 16.
- I = 1295, Q = 1296 → sym 1110, err_i = 647, err_q = -647, erase = 1. Then I = 0, Q = -1 → sym 1101, err_i = -648, err_q = +647, erase = 1.
- Keep in_valid at 1 and hold out_ready low for 5 cycles → in_ready falls once S1 and S2 are full; no sample is lost or duplicated; out_sym stays stable during the stall; order is preserved after release.
- Preload sym_count to 0xFFFE, then send 3 symbols → count stops at 0xFFFF. Assert clr_stats in the same cycle as a handshake → both counters read 0 on the next cycle.
- Assert rst_n low for 1 cycle with 2 samples in flight → out_valid is 0 next cycle, counters are 0, and the next accepted sample appears after 2 cycles.
- I = -2048, Q = 2047 → sym 0010, err_i = -105, err_q = +104, erase = 0.
